// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard controls, redirect, imem port and IF/ID outputs.
// Optional perf counters appear when FETCH_PERF_CNT_EN is defined.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  STALL_F;
    logic                  STALL_D;
    logic                  FLUSH_D;
    logic                  BRANCH_TAKEN_E;
    logic [ADDR_WIDTH-1:0] BRANCH_TARGET_E;
    logic [ADDR_WIDTH-1:0] PC_F;
    logic [31:0]           INSTR_F;
    logic [31:0]           INSTR_D;
    logic [ADDR_WIDTH-1:0] PC_PLUS4_D;
    logic [ADDR_WIDTH-1:0] PC_PLUS8_D;
    logic                  VALID_D;
    logic                  MISALIGN;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]           FETCH_CNT;
    logic [31:0]           STALL_CNT;
`endif

    modport master (
        output STALL_F,
        output STALL_D,
        output FLUSH_D,
        output BRANCH_TAKEN_E,
        output BRANCH_TARGET_E,
        output INSTR_F,
        input  PC_F,
        input  INSTR_D,
        input  PC_PLUS4_D,
        input  PC_PLUS8_D,
        input  VALID_D,
`ifdef FETCH_PERF_CNT_EN
        input  FETCH_CNT,
        input  STALL_CNT,
`endif
        input  MISALIGN
    );

    modport slave (
        input  STALL_F,
        input  STALL_D,
        input  FLUSH_D,
        input  BRANCH_TAKEN_E,
        input  BRANCH_TARGET_E,
        input  INSTR_F,
        output PC_F,
        output INSTR_D,
        output PC_PLUS4_D,
        output PC_PLUS8_D,
        output VALID_D,
`ifdef FETCH_PERF_CNT_EN
        output FETCH_CNT,
        output STALL_CNT,
`endif
        output MISALIGN
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem address, IF/ID pipeline register.
// Define FETCH_PERF_CNT_EN to add fetch/stall performance counters.
module fetch_stage #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter logic [31:0] NOP_INSTR  = 32'hE1A00000
) (
    input logic           CLK,
    input logic           RESET,
    fetch_stage_if.slave  bus
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [31:0]           r_instr;
    logic [ADDR_WIDTH-1:0] r_pc4;
    logic [ADDR_WIDTH-1:0] r_pc8;
    logic                  r_valid;
    logic                  r_misalign;

    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_pc_plus8;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_load;
    logic                  w_stall_f;

    assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);
    assign w_pc_plus8 = r_pc + ADDR_WIDTH'(8);
    assign w_target   = {bus.BRANCH_TARGET_E[ADDR_WIDTH-1:2], 2'b00};
    assign w_load     = !bus.FLUSH_D && !bus.STALL_D;
    assign w_stall_f  = bus.STALL_F && !bus.BRANCH_TAKEN_E;

    // Branch outranks stall so a stalled fetch can still be redirected.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else if (bus.BRANCH_TAKEN_E) begin
            r_pc <= w_target;
            if (bus.BRANCH_TARGET_E[1:0] != 2'b00)
                r_misalign <= 1'b1;
        end else if (!bus.STALL_F) begin
            r_pc <= w_pc_plus4;
        end
    end

    // A bubble keeps the old PC+4/PC+8 so only the word and valid change.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= '0;
            r_pc8   <= '0;
            r_valid <= 1'b0;
        end else if (bus.FLUSH_D) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!bus.STALL_D) begin
            r_instr <= bus.INSTR_F;
            r_pc4   <= w_pc_plus4;
            r_pc8   <= w_pc_plus8;
            r_valid <= 1'b1;
        end
    end

    assign bus.PC_F       = r_pc;
    assign bus.INSTR_D    = r_instr;
    assign bus.PC_PLUS4_D = r_pc4;
    assign bus.PC_PLUS8_D = r_pc8;
    assign bus.VALID_D    = r_valid;
    assign bus.MISALIGN   = r_misalign;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_load && r_fetch_cnt != '1)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_stall_f && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.FETCH_CNT = r_fetch_cnt;
    assign bus.STALL_CNT = r_stall_cnt;
`else
    logic w_unused;
    assign w_unused = w_stall_f;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a byte-pattern instruction memory.
// Memory byte at address a holds a[7:0]+1.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic CLK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_stage_if #(.ADDR_WIDTH(32)) bus ();

    fetch_stage #(
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0),
        .NOP_INSTR (NOP)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1};
    endfunction

    assign bus.INSTR_F = mem_rd(bus.PC_F);

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(logic sf, logic sd, logic fd,
                         logic bt, logic [31:0] tgt);
        bus.STALL_F         = sf;
        bus.STALL_D         = sd;
        bus.FLUSH_D         = fd;
        bus.BRANCH_TAKEN_E  = bt;
        bus.BRANCH_TARGET_E = tgt;
    endtask

    initial begin
        RESET = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        tick();
        tick();
        chk("rst_pc",    bus.PC_F,       32'h0);
        chk("rst_instr", bus.INSTR_D,    NOP);
        chk("rst_valid", 32'(bus.VALID_D), 32'd0);
        chk("rst_pc4",   bus.PC_PLUS4_D, 32'h0);
        chk("rst_pc8",   bus.PC_PLUS8_D, 32'h0);
        chk("rst_mis",   32'(bus.MISALIGN), 32'd0);

        RESET = 1'b0;
        tick();
        chk("s1_pc",    bus.PC_F,       32'h4);
        chk("s1_instr", bus.INSTR_D,    32'h04030201);
        chk("s1_pc4",   bus.PC_PLUS4_D, 32'h4);
        chk("s1_pc8",   bus.PC_PLUS8_D, 32'h8);
        chk("s1_valid", 32'(bus.VALID_D), 32'd1);
        tick();
        chk("s2_pc",    bus.PC_F,       32'h8);
        chk("s2_instr", bus.INSTR_D,    32'h08070605);
        chk("s2_pc4",   bus.PC_PLUS4_D, 32'h8);
        tick();
        chk("s3_pc",    bus.PC_F,       32'hC);
        chk("s3_instr", bus.INSTR_D,    32'h0C0B0A09);
        tick();
        chk("s4_pc",    bus.PC_F,       32'h10);
        chk("s4_instr", bus.INSTR_D,    32'h100F0E0D);
        chk("s4_pc4",   bus.PC_PLUS4_D, 32'h10);

        drive(1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_pc",    bus.PC_F,       32'h10);
            chk("stl_instr", bus.INSTR_D,    32'h100F0E0D);
            chk("stl_valid", 32'(bus.VALID_D), 32'd1);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("cnt_stall3", bus.STALL_CNT, 32'd3);
        chk("cnt_fetch4", bus.FETCH_CNT, 32'd4);
`endif

        drive(1, 0, 1, 1, 32'h203);
        tick();
        chk("mb_pc",    bus.PC_F,       32'h200);
        chk("mb_valid", 32'(bus.VALID_D), 32'd0);
        chk("mb_instr", bus.INSTR_D,    NOP);
        chk("mb_mis",   32'(bus.MISALIGN), 32'd1);
        chk("mb_pc4",   bus.PC_PLUS4_D, 32'h10);
        chk("mb_pc8",   bus.PC_PLUS8_D, 32'h14);

        drive(0, 0, 0, 0, 32'h0);
        tick();
        chk("tg_pc",    bus.PC_F,       32'h204);
        chk("tg_instr", bus.INSTR_D,    32'h04030201);
        chk("tg_pc4",   bus.PC_PLUS4_D, 32'h204);
        chk("tg_pc8",   bus.PC_PLUS8_D, 32'h208);
        chk("tg_mis",   32'(bus.MISALIGN), 32'd1);

        drive(0, 1, 1, 0, 32'h0);
        tick();
        chk("fs_pc",    bus.PC_F,       32'h208);
        chk("fs_valid", 32'(bus.VALID_D), 32'd0);
        chk("fs_instr", bus.INSTR_D,    NOP);
        chk("fs_pc4",   bus.PC_PLUS4_D, 32'h204);

        drive(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("sf_pc",    bus.PC_F,       32'h208);
            chk("sf_instr", bus.INSTR_D,    32'h0C0B0A09);
            chk("sf_pc4",   bus.PC_PLUS4_D, 32'h20C);
            chk("sf_valid", 32'(bus.VALID_D), 32'd1);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("cnt_stall5", bus.STALL_CNT, 32'd5);
`endif

        drive(0, 0, 1, 1, 32'hFFFFFFFC);
        tick();
        chk("wb_pc",    bus.PC_F,       32'hFFFFFFFC);
        chk("wb_valid", 32'(bus.VALID_D), 32'd0);
        drive(0, 0, 0, 0, 32'h0);
        tick();
        chk("wr_pc",    bus.PC_F,       32'h0);
        chk("wr_instr", bus.INSTR_D,    32'h00FFFEFD);
        chk("wr_pc4",   bus.PC_PLUS4_D, 32'h0);
        chk("wr_pc8",   bus.PC_PLUS8_D, 32'h4);
        chk("wr_mis",   32'(bus.MISALIGN), 32'd1);

        RESET = 1'b1;
        drive(1, 0, 1, 1, 32'h301);
        tick();
        chk("mr_pc",    bus.PC_F,       32'h0);
        chk("mr_instr", bus.INSTR_D,    NOP);
        chk("mr_valid", 32'(bus.VALID_D), 32'd0);
        chk("mr_pc4",   bus.PC_PLUS4_D, 32'h0);
        chk("mr_mis",   32'(bus.MISALIGN), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("mr_scnt", bus.STALL_CNT, 32'd0);
`endif
        RESET = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        tick();
        chk("rr_pc",    bus.PC_F,       32'h4);
        chk("rr_valid", 32'(bus.VALID_D), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("rr_fcnt", bus.FETCH_CNT, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined ARM core.
- Holds the program counter and drives the byte address of the combinational, byte-addressed, little-endian instruction memory.
- Captures the 32-bit word that memory returns into the IF/ID pipeline register.
- Handles sequential PC advance, stalls, branch redirects and decode-stage flushes from the hazard unit.

Parameters:
- ADDR_WIDTH, 32, width of PC and all address ports.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'hE1A00000, instruction word injected into decode on flush or reset (MOV R0,R0).

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset.
- STALL_F  in  1  hold PC.
- STALL_D  in  1  hold IF/ID register.
- FLUSH_D  in  1  replace IF/ID contents with bubble.
- BRANCH_TAKEN_E  in  1  redirect request from execute.
- BRANCH_TARGET_E  in  ADDR_WIDTH  redirect target address.
- PC_F  out  ADDR_WIDTH  current PC; drives instruction memory ADDR.
- INSTR_F  in  32  word from instruction memory RD, combinational on PC_F.
- INSTR_D  out  32  registered instruction for decode.
- PC_PLUS4_D  out  ADDR_WIDTH  registered PC+4 of INSTR_D.
- PC_PLUS8_D  out  ADDR_WIDTH  registered PC+8 of INSTR_D (architectural R15 read value).
- VALID_D  out  1  INSTR_D is a real fetched instruction, not a bubble.
- MISALIGN  out  1  sticky flag: a redirect target had bits [1:0] nonzero.

Behaviour:
- Clock and reset: single clock CLK; RESET is synchronous, active-high, sampled on rising CLK. All state is updated only on rising CLK.
- Reset values:
  - PC_F = RESET_PC
  - INSTR_D = NOP_INSTR
  - PC_PLUS4_D = 0, PC_PLUS8_D = 0
  - VALID_D = 0, MISALIGN = 0
  - RESET mid-operation discards any pending stall, branch or flush in that cycle.
- PC update priority, per edge: RESET > BRANCH_TAKEN_E > STALL_F > sequential.
  - Branch: PC_F <= {BRANCH_TARGET_E[ADDR_WIDTH-1:2], 2'b00}. MISALIGN <= 1 if BRANCH_TARGET_E[1:0] != 0; it stays set until RESET.
  - Stall: PC_F holds.
  - Sequential: PC_F <= PC_F + 4, modulo 2^ADDR_WIDTH. 0xFFFFFFFC wraps to 0x00000000.
- IF/ID update priority, per edge: RESET > FLUSH_D > STALL_D > load.
  - Flush: INSTR_D <= NOP_INSTR, VALID_D <= 0. PC_PLUS4_D and PC_PLUS8_D hold their values.
  - Stall: all IF/ID outputs hold.
  - Load: INSTR_D <= INSTR_F, PC_PLUS4_D <= PC_F+4, PC_PLUS8_D <= PC_F+8 (both wrap mod 2^ADDR_WIDTH), VALID_D <= 1.
- Latency and ordering:
  - Instruction at PC_F in cycle n appears on INSTR_D in cycle n+1.
  - Redirect target appears on PC_F one cycle after BRANCH_TAKEN_E is sampled high, and on INSTR_D one cycle after that.
  - The hazard unit asserts FLUSH_D together with BRANCH_TAKEN_E; this block does not flush implicitly.
- Simultaneous events:
  - BRANCH_TAKEN_E with STALL_F: branch wins.
  - FLUSH_D with STALL_D: flush wins.
  - STALL_F without STALL_D is legal. D keeps loading the same PC_F word each cycle.
- Sequencing: one internal sequence register per field; no combinational path from INSTR_F to any output.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra output ports are present:
  - FETCH_CNT (32 bits): increments on every edge where IF/ID performs a load.
  - STALL_CNT (32 bits): increments on every edge where STALL_F = 1 and BRANCH_TAKEN_E = 0.
  - Both counters saturate at 32'hFFFFFFFF and clear on RESET.
- When not defined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert RESET 2 cycles with RESET_PC=0 -> PC_F=0, INSTR_D=E1A00000, VALID_D=0; first edge after release gives PC_F=4, INSTR_D=mem word @0 (e.g. 04030201 for bytes 01,02,03,04), PC_PLUS8_D=8, VALID_D=1.
- Sequential: run 4 cycles from PC 0 -> PC_F sequence 4, 8, 0xC, 0x10; PC_PLUS4_D trails PC_F by one cycle.
- Stall: STALL_F=STALL_D=1 for 3 cycles at PC_F=0x10 -> PC_F, INSTR_D and VALID_D frozen; STALL_CNT +3 when FETCH_PERF_CNT_EN is defined.
- Misaligned branch: BRANCH_TAKEN_E=1 with target 0x203 and FLUSH_D=1 while STALL_F=1 -> next PC_F=0x200, VALID_D=0, INSTR_D=E1A00000, MISALIGN=1 and stays 1 until RESET.
- Flush versus stall: FLUSH_D=1 and STALL_D=1 together -> bubble inserted (VALID_D=0); PC_PLUS4_D unchanged.
- Wrap-around: branch to 0xFFFFFFFC -> next edge PC_F=0, PC_PLUS4_D=0, PC_PLUS8_D=4.
